// File: rtl/word_banner_renderer_pkg.sv
// Shared constants and FSM state encoding for the word banner renderer.
//   H_VISIBLE / V_VISIBLE : visible raster size of the VGA timing in use
//   DEF_WORD_W / DEF_WORD_H : default bitmap geometry of the word ROMs
//   banner_state_e : blink FSM states (IDLE=0, STEADY=1, BLINK_ON=2, BLINK_OFF=3)
package word_banner_renderer_pkg;

  localparam int unsigned H_VISIBLE  = 640;
  localparam int unsigned V_VISIBLE  = 480;
  localparam int unsigned DEF_WORD_W = 224;
  localparam int unsigned DEF_WORD_H = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STEADY    = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } banner_state_e;

endpackage

// File: rtl/word_banner_renderer_blink_fsm.sv
// banner_blink_fsm: decides per frame whether the banner is visible.
// All transitions happen on a frame start so a frame is never torn.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   fs         : frame-start strobe (already qualified by the pixel tick)
//   show       : request banner visible
//   blink_en   : request blinking while shown
//   visible    : banner may be drawn in the current frame
module banner_blink_fsm
  import word_banner_renderer_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fs,
  input  logic show,
  input  logic blink_en,
  output logic visible
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  banner_state_e    state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    visible  = (state == STEADY) || (state == BLINK_ON);
    if (fs) begin
      case (state)
        IDLE: begin
          if (show) begin
            state_nx = blink_en ? BLINK_ON : STEADY;
            cnt_nx   = '0;
          end
        end
        STEADY: begin
          if (!show) begin
            state_nx = IDLE;
          end else if (blink_en) begin
            state_nx = BLINK_ON;
            cnt_nx   = '0;
          end
        end
        BLINK_ON, BLINK_OFF: begin
          if (!show) begin
            state_nx = IDLE;
          end else if (!blink_en) begin
            state_nx = STEADY;
          end else if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/word_banner_renderer.sv
// word_banner_renderer: reader side of a WORD_H x WORD_W word bitmap ROM.
// Turns the raster position into a ROM row address, picks the pixel out of
// the returned row and emits one banner pixel per pixel tick, two ticks later.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   pix_tick      : pixel-rate enable; every register holds while low
//   hcount/vcount : raster position
//   video_on      : visible-area flag
//   show/blink_en : banner requests, sampled at frame start
//   drom_addr_num : registered ROM row address
//   drom_data_num : ROM row, bit 0 = leftmost pixel (combinational ROM)
//   pixel_on      : banner pixel lit, aligned with video_on_d
//   video_on_d    : video_on delayed to match pixel_on
//   rgb           : COLOR when pixel_on, else 0
module word_banner_renderer
  import word_banner_renderer_pkg::*;
#(
  parameter int unsigned WORD_W       = DEF_WORD_W,
  parameter int unsigned WORD_H       = DEF_WORD_H,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned X0           = 208,
  parameter int unsigned Y0           = 224,
  parameter int unsigned SCALE_SH     = 0,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter logic [11:0] COLOR        = 12'hFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_tick,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              video_on,
  input  logic              show,
  input  logic              blink_en,
  output logic [ADDR_W-1:0] drom_addr_num,
  input  logic [0:WORD_W-1] drom_data_num,
  output logic              pixel_on,
  output logic              video_on_d,
  output logic [11:0]       rgb
);

  localparam int unsigned COL_W = $clog2(WORD_W);
  localparam int unsigned X_END = X0 + (WORD_W << SCALE_SH);
  localparam int unsigned Y_END = Y0 + (WORD_H << SCALE_SH);

  logic [10:0]      dx, dy;
  logic             in_box, fs, visible;
  logic [COL_W-1:0] col_s1;
  logic             in_box_s1, video_on_s1;
  logic             rom_bit, pix_nx;

  assign dx     = {1'b0, hcount} - 11'(X0);
  assign dy     = {1'b0, vcount} - 11'(Y0);
  assign in_box = (32'(hcount) >= X0) && (32'(hcount) < X_END) &&
                  (32'(vcount) >= Y0) && (32'(vcount) < Y_END);
  assign fs     = pix_tick && (hcount == '0) && (vcount == '0);

  banner_blink_fsm #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .fs      (fs),
    .show    (show),
    .blink_en(blink_en),
    .visible (visible)
  );

  // Stage 1: row address (held outside the box so the ROM output stays
  // stable), column index and qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drom_addr_num <= '0;
      col_s1        <= '0;
      in_box_s1     <= 1'b0;
      video_on_s1   <= 1'b0;
    end else if (pix_tick) begin
      if (in_box) begin
        drom_addr_num <= ADDR_W'(dy >> SCALE_SH);
      end
      col_s1      <= COL_W'(dx >> SCALE_SH);
      in_box_s1   <= in_box;
      video_on_s1 <= video_on;
    end
  end

  // Out-of-box column values can exceed the row width; they are masked by
  // in_box_s1 anyway, so just avoid indexing past the row.
  always_comb begin
    rom_bit = 1'b0;
    if (32'(col_s1) < WORD_W) begin
      rom_bit = drom_data_num[col_s1];
    end
    pix_nx = rom_bit & in_box_s1 & video_on_s1 & visible;
  end

  // Stage 2: registered pixel and colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_on   <= 1'b0;
      video_on_d <= 1'b0;
      rgb        <= '0;
    end else if (pix_tick) begin
      pixel_on   <= pix_nx;
      video_on_d <= video_on_s1;
      rgb        <= pix_nx ? COLOR : '0;
    end
  end

endmodule

// File: tb/tb_word_banner_renderer.sv
module tb_word_banner_renderer;
  import word_banner_renderer_pkg::*;

  localparam int BF = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pix_tick = 1'b0;
  logic [9:0]   hcount = '0;
  logic [9:0]   vcount = '0;
  logic         video_on = 1'b0;
  logic         show = 1'b0;
  logic         blink_en = 1'b0;

  logic [4:0]   addr0, addr1;
  logic [0:223] data0, data1;
  logic         pix0, pix1, vod0, vod1;
  logic [11:0]  rgb0, rgb1;

  always #5 clk = ~clk;

  word_banner_renderer #(.SCALE_SH(0), .BLINK_FRAMES(BF), .COLOR(12'hFFF)) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .show(show), .blink_en(blink_en), .drom_addr_num(addr0),
    .drom_data_num(data0), .pixel_on(pix0), .video_on_d(vod0), .rgb(rgb0)
  );

  word_banner_renderer #(.SCALE_SH(1), .BLINK_FRAMES(BF), .COLOR(12'hFFF)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .show(show), .blink_en(blink_en), .drom_addr_num(addr1),
    .drom_data_num(data1), .pixel_on(pix1), .video_on_d(vod1), .rgb(rgb1)
  );

  // ROM pattern: row 0 has bit0=0, bit1=1.
  function automatic logic rom_bit(input int r, input int c);
    return ((c + 3 * r) % 5) == 1;
  endfunction

  always_comb begin
    data0 = '0;
    data1 = '0;
    for (int i = 0; i < 224; i++) begin
      data0[i] = rom_bit(int'(addr0), i);
      data1[i] = rom_bit(int'(addr1), i);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic p0;
    logic p1;
    logic vo;
  } exp_t;

  exp_t q[$];
  int   m_state = 0;
  int   m_cnt = 0;
  int   m_addr0 = 0;
  int   m_addr1 = 0;
  logic last_p0 = 1'b0;

  task automatic model_fs();
    case (m_state)
      0: if (show) begin m_state = blink_en ? 2 : 1; m_cnt = 0; end
      1: if (!show) m_state = 0;
         else if (blink_en) begin m_state = 2; m_cnt = 0; end
      default: begin
        if (!show) m_state = 0;
        else if (!blink_en) m_state = 1;
        else if (m_cnt == BF - 1) begin m_cnt = 0; m_state = (m_state == 2) ? 3 : 2; end
        else m_cnt++;
      end
    endcase
  endtask

  task automatic model_lane(input int h, input int v, input int sh, input logic vo,
                            input logic vis, input int addr_in,
                            output int addr_out, output logic p);
    logic inb;
    inb = (h >= 208) && (h < 208 + (224 << sh)) && (v >= 224) && (v < 224 + (32 << sh));
    addr_out = inb ? ((v - 224) >> sh) : addr_in;
    p = inb && vo && vis && rom_bit(addr_out, (h - 208) >> sh);
  endtask

  task automatic step(input int h, input int v, input logic vo);
    exp_t e;
    logic vis;
    int   a;
    hcount   = 10'(h);
    vcount   = 10'(v);
    video_on = vo;
    pix_tick = 1'b1;
    if (h == 0 && v == 0) model_fs();
    vis = (m_state == 1) || (m_state == 2);
    model_lane(h, v, 0, vo, vis, m_addr0, a, e.p0); m_addr0 = a;
    model_lane(h, v, 1, vo, vis, m_addr1, a, e.p1); m_addr1 = a;
    e.vo = vo;
    q.push_back(e);
    @(posedge clk); #1;
    check_eq("addr0", 32'(addr0), m_addr0);
    check_eq("addr1", 32'(addr1), m_addr1);
    if (q.size() >= 2) begin
      e = q.pop_front();
      last_p0 = e.p0;
      check_eq("pix0", 32'(pix0), 32'(e.p0));
      check_eq("rgb0", 32'(rgb0), e.p0 ? 32'hFFF : 32'h0);
      check_eq("vod0", 32'(vod0), 32'(e.vo));
      check_eq("pix1", 32'(pix1), 32'(e.p1));
      check_eq("rgb1", 32'(rgb1), e.p1 ? 32'hFFF : 32'h0);
      check_eq("vod1", 32'(vod1), 32'(e.vo));
    end
  endtask

  task automatic frame_probe();
    step(0, 0, 1'b1);
    step(209, 224, 1'b1);
    step(209, 224, 1'b1);
    step(211, 224, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pix", 32'(pix0), 0);
    check_eq("rst_rgb", 32'(rgb0), 0);
    check_eq("rst_vod", 32'(vod0), 0);
    check_eq("rst_addr", 32'(addr0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    show  = 1'b1;
    @(posedge clk); #1;

    // Steady banner, geometry and edges.
    step(0, 0, 1'b1);
    step(208, 224, 1'b1);
    step(209, 224, 1'b1);
    step(210, 224, 1'b1);
    step(211, 224, 1'b1);
    step(207, 230, 1'b1);
    step(432, 230, 1'b1);
    step(208, 255, 1'b1);
    step(431, 255, 1'b1);
    step(210, 226, 1'b1);
    step(211, 227, 1'b1);
    step(655, 287, 1'b1);
    step(656, 287, 1'b1);
    step(209, 224, 1'b0);
    step(213, 228, 1'b1);
    step(H_VISIBLE - 1, V_VISIBLE - 1, 1'b1);
    step(209, 224, 1'b1);
    step(209, 224, 1'b1);

    // Pixel tick held low: outputs and address frozen.
    pix_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hcount = 10'(300 + 7 * i);
      vcount = 10'(240 + i);
      @(posedge clk); #1;
      check_eq("frz_pix", 32'(pix0), 32'(last_p0));
      check_eq("frz_addr", 32'(addr0), m_addr0);
    end
    step(209, 224, 1'b1);

    // Blinking: ON for BF frames, OFF for BF, ON again.
    blink_en = 1'b1;
    for (int f = 0; f < 7; f++) frame_probe();

    // Drop show mid-frame; banner stays until next frame start.
    blink_en = 1'b0;
    step(0, 0, 1'b1);
    step(209, 224, 1'b1);
    show = 1'b0;
    step(209, 224, 1'b1);
    step(209, 224, 1'b1);
    frame_probe();
    frame_probe();

    // Reset mid-banner.
    show = 1'b1;
    step(0, 0, 1'b1);
    step(211, 225, 1'b1);
    step(211, 225, 1'b1);
    step(211, 225, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_pix", 32'(pix0), 0);
    check_eq("arst_rgb", 32'(rgb0), 0);
    check_eq("arst_vod", 32'(vod0), 0);
    check_eq("arst_addr", 32'(addr0), 0);
    check_eq("arst_pix1", 32'(pix1), 0);
    pix_tick = 1'b0;
    m_state = 0;
    m_cnt   = 0;
    m_addr0 = 0;
    m_addr1 = 0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(211, 225, 1'b1);
    step(211, 225, 1'b1);
    step(211, 225, 1'b1);
    step(0, 0, 1'b1);
    step(211, 225, 1'b1);
    step(211, 225, 1'b1);
    step(H_VISIBLE - 1, V_VISIBLE - 1, 1'b1);
    step(H_VISIBLE - 1, V_VISIBLE - 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
